stp_wrapper: RTL and testbench

Serial-to-parallel input collector for the FFT datapath. It accepts one 16-bit sample per strobe and assembles a 32-sample frame. It hands the frame to the FFT core as a parallel vector through a valid/ack handshake. It is double-buffered, so the next frame can be collected while the core still holds the previous one.

---
 rtl/fft_pkg.sv | 11 +
 rtl/stp_wrapper_if.sv | 22 ++
 rtl/stp_wrapper.sv | 71 +++++++
 tb/tb_stp_wrapper.sv | 127 ++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types: frame geometry, sample/frame types, collector FSM states.
package fft_pkg;
  localparam int NUM_SAMPLES = 32;
  localparam int SAMPLE_W    = 16;
  localparam int CNT_W       = $clog2(NUM_SAMPLES);

  typedef logic [SAMPLE_W-1:0]     sample_t;
  typedef sample_t [NUM_SAMPLES-1:0] frame_t;

  typedef enum logic {COLLECT, FULL} stp_state_e;
endpackage

// File: rtl/stp_wrapper_if.sv
// Serial sample input plus parallel frame valid/ack handshake of the input collector.
interface stp_wrapper_if;
  import fft_pkg::*;

  logic    in_strobe;
  sample_t serial_in;
  logic    in_ready;
  frame_t  data_par_in;
  logic    data_valid;
  logic    data_ack;
  logic    overrun;

  modport master (
    output in_strobe, serial_in, data_ack,
    input  in_ready, data_par_in, data_valid, overrun
  );

  modport slave (
    input  in_strobe, serial_in, data_ack,
    output in_ready, data_par_in, data_valid, overrun
  );
endinterface

// File: rtl/stp_wrapper.sv
// Double-buffered serial-to-parallel collector: shifts samples into a collect frame,
// then hands complete frames to the FFT core through a valid/ack output register.
module stp_wrapper
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  stp_wrapper_if.slave  bus
);

  stp_state_e       state, state_nxt;
  frame_t           col_q, col_nxt, par_q, load_frame;
  logic [CNT_W-1:0] cnt;
  logic             valid_q, ovr_q;
  logic             accept, last, xfer_ok, load;

  assign bus.in_ready    = (state == COLLECT);
  assign bus.data_par_in = par_q;
  assign bus.data_valid  = valid_q;
  assign bus.overrun     = ovr_q;

  assign accept  = bus.in_strobe && bus.in_ready;
  assign last    = accept && (cnt == CNT_W'(NUM_SAMPLES - 1));
  assign xfer_ok = !valid_q || bus.data_ack;
  // Right shift so the first sample ends up in element 0 after a full frame.
  assign col_nxt = {bus.serial_in, col_q[NUM_SAMPLES-1:1]};

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_frame = col_nxt;
    unique case (state)
      COLLECT: begin
        if (last) begin
          if (xfer_ok) load = 1'b1;
          else         state_nxt = FULL;
        end
      end
      FULL: begin
        // Only reachable with valid_q set, so an ack here is always honoured.
        load_frame = col_q;
        if (bus.data_ack) begin
          load      = 1'b1;
          state_nxt = COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      col_q   <= '0;
      par_q   <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        col_q <= col_nxt;
        cnt   <= cnt + 1'b1;
      end
      if (load)                        par_q   <= load_frame;
      if (load)                        valid_q <= 1'b1;
      else if (bus.data_ack && valid_q) valid_q <= 1'b0;
      if (bus.in_strobe && !bus.in_ready) ovr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stp_wrapper.sv
// Directed bench for stp_wrapper: frame assembly, back-pressure, overrun, ack corner cases, reset.
module tb_stp_wrapper;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  stp_wrapper_if bus();

  stp_wrapper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe n consecutive samples base, base+1, ...; optionally ack on the last strobe edge.
  task automatic send(input logic [15:0] base, input int n, input logic ack_last);
    for (int i = 0; i < n; i++) begin
      bus.in_strobe = 1'b1;
      bus.serial_in = base + 16'(i);
      bus.data_ack  = ack_last && (i == n - 1);
      tick();
    end
    bus.in_strobe = 1'b0;
    bus.data_ack  = 1'b0;
  endtask

  initial begin
    bus.in_strobe = 1'b0;
    bus.serial_in = '0;
    bus.data_ack  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid",   32'(bus.data_valid), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_ready",   32'(bus.in_ready), 32'd1);
    chk("rst_par0",    32'(bus.data_par_in[0]), 32'h0);

    // First frame, no ack: valid appears right after the 32nd strobe edge.
    send(16'h0001, 31, 1'b0);
    chk("f1_valid_early", 32'(bus.data_valid), 32'd0);
    send(16'h0020, 1, 1'b0);
    chk("f1_valid",  32'(bus.data_valid), 32'd1);
    chk("f1_par0",   32'(bus.data_par_in[0]), 32'h0001);
    chk("f1_par31",  32'(bus.data_par_in[31]), 32'h0020);
    chk("f1_ready",  32'(bus.in_ready), 32'd1);

    // Second frame while first is held: collector goes FULL.
    send(16'h0100, 32, 1'b0);
    chk("f2_ready_full", 32'(bus.in_ready), 32'd0);
    chk("f2_par0_held",  32'(bus.data_par_in[0]), 32'h0001);
    chk("f2_valid_held", 32'(bus.data_valid), 32'd1);

    // Strobe while not ready: dropped, sticky overrun.
    send(16'hDEAD, 1, 1'b0);
    chk("ovr_set",   32'(bus.overrun), 32'd1);
    chk("ovr_ready", 32'(bus.in_ready), 32'd0);

    // Ack releases the FULL frame.
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
    chk("f2_par0",  32'(bus.data_par_in[0]), 32'h0100);
    chk("f2_par31", 32'(bus.data_par_in[31]), 32'h011F);
    chk("f2_valid", 32'(bus.data_valid), 32'd1);
    chk("f2_ready", 32'(bus.in_ready), 32'd1);

    // 32nd strobe coincides with ack: seamless swap.
    send(16'h0200, 32, 1'b1);
    chk("f3_valid",   32'(bus.data_valid), 32'd1);
    chk("f3_par0",    32'(bus.data_par_in[0]), 32'h0200);
    chk("f3_par31",   32'(bus.data_par_in[31]), 32'h021F);
    chk("f3_ready",   32'(bus.in_ready), 32'd1);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Ack with no new frame clears valid, keeps data.
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
    chk("ack_clr_valid", 32'(bus.data_valid), 32'd0);
    chk("ack_clr_par0",  32'(bus.data_par_in[0]), 32'h0200);
    bus.data_ack = 1'b1;
    tick();
    bus.data_ack = 1'b0;
    chk("ack_idle_valid", 32'(bus.data_valid), 32'd0);
    chk("ack_idle_par31", 32'(bus.data_par_in[31]), 32'h021F);
    chk("ack_idle_ready", 32'(bus.in_ready), 32'd1);

    // Reset mid-frame discards the partial frame.
    send(16'h0300, 10, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid",   32'(bus.data_valid), 32'd0);
    chk("mid_rst_overrun", 32'(bus.overrun), 32'd0);
    chk("mid_rst_par0",    32'(bus.data_par_in[0]), 32'h0);
    rst = 1'b0;
    send(16'h0A00, 32, 1'b0);
    chk("f4_valid", 32'(bus.data_valid), 32'd1);
    chk("f4_par0",  32'(bus.data_par_in[0]), 32'h0A00);
    chk("f4_par9",  32'(bus.data_par_in[9]), 32'h0A09);
    chk("f4_par31", 32'(bus.data_par_in[31]), 32'h0A1F);
    chk("f4_ovr",   32'(bus.overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
